// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage.
// Control bundle bit positions and stage FSM encodings.
package mem_wb_stage_pkg;

    localparam int MEM_BRANCH  = 3;
    localparam int MEM_READ    = 2;
    localparam int MEM_WRITE   = 1;
    localparam int MEM_BNE     = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for an outstanding data-memory access.
// Flags abort when TIMEOUT cycles pass without an ack.
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_wait,
    input  logic i_ack,
    output logic o_abort
);

    logic [CNT_W-1:0] r_cnt;

    assign o_abort = i_wait & ~i_ack & (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(1);
        end else if (i_wait) begin
            if (i_ack | o_abort)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: branch resolve, handshaked data access, MEM/WB register.
// Stalls upstream while an access is outstanding.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PCPlus4PlusOffReg,
    input  logic              EqualReg,
    input  logic [DATA_W-1:0] ResultReg,
    input  logic [DATA_W-1:0] OutBReg,
    input  logic [4:0]        WrRegReg,
    input  logic [3:0]        MEMReg,
    input  logic [1:0]        WBReg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              pc_src,
    output logic [31:0]       branch_target,
    output logic              mem_err,
    output logic [1:0]        WBOut,
    output logic [DATA_W-1:0] ReadDataOut,
    output logic [DATA_W-1:0] ResultOut,
    output logic [4:0]        WrRegOut
);

    state_t r_state;
    state_t w_next;

    logic              w_mem_op;
    logic              w_abort;
    logic              w_stall;
    logic              w_start;
    logic              r_mem_err;
    logic [1:0]        r_wb;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_wrreg;

    assign w_mem_op = MEMReg[MEM_READ] | MEMReg[MEM_WRITE];
    assign w_stall  = w_mem_op & ~mem_ack & ~w_abort;
    assign w_start  = (r_state == ST_IDLE) & w_mem_op & ~mem_ack;

    assign pc_src = (MEMReg[MEM_BRANCH] & EqualReg)
                  | (MEMReg[MEM_BNE] & ~EqualReg);
    assign branch_target = PCPlus4PlusOffReg;

    // Write wins when both read and write bits are set.
    assign mem_req   = w_mem_op;
    assign mem_we    = MEMReg[MEM_WRITE];
    assign mem_addr  = 32'(ResultReg);
    assign mem_wdata = OutBReg;
    assign stall     = w_stall;

    assign mem_err     = r_mem_err;
    assign WBOut       = r_wb;
    assign ReadDataOut = r_rdata;
    assign ResultOut   = r_result;
    assign WrRegOut    = r_wrreg;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_wait  (r_state == ST_WAIT),
        .i_ack   (mem_ack),
        .o_abort (w_abort)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_mem_op & ~mem_ack) w_next = ST_WAIT;
            ST_WAIT: if (mem_ack | w_abort)   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_err <= 1'b0;
            r_wb      <= '0;
            r_rdata   <= '0;
            r_result  <= '0;
            r_wrreg   <= '0;
        end else begin
            r_mem_err <= w_abort;
            if (w_stall) begin
                r_wb <= '0;
            end else if (w_abort) begin
                r_wb    <= '0;
                r_wrreg <= '0;
            end else begin
                r_wb     <= WBReg;
                r_result <= ResultReg;
                r_wrreg  <= WrRegReg;
                if (MEMReg[MEM_READ])
                    r_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a short watchdog timeout.
// Inputs change on the falling edge; outputs sampled away from rising edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCPlus4PlusOffReg;
    logic        EqualReg;
    logic [31:0] ResultReg;
    logic [31:0] OutBReg;
    logic [4:0]  WrRegReg;
    logic [3:0]  MEMReg;
    logic [1:0]  WBReg;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_err;
    logic [1:0]  WBOut;
    logic [31:0] ReadDataOut;
    logic [31:0] ResultOut;
    logic [4:0]  WrRegOut;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W  (32),
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .PCPlus4PlusOffReg (PCPlus4PlusOffReg),
        .EqualReg          (EqualReg),
        .ResultReg         (ResultReg),
        .OutBReg           (OutBReg),
        .WrRegReg          (WrRegReg),
        .MEMReg            (MEMReg),
        .WBReg             (WBReg),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .stall             (stall),
        .pc_src            (pc_src),
        .branch_target     (branch_target),
        .mem_err           (mem_err),
        .WBOut             (WBOut),
        .ReadDataOut       (ReadDataOut),
        .ResultOut         (ResultOut),
        .WrRegOut          (WrRegOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        PCPlus4PlusOffReg = '0;
        EqualReg = 1'b0;
        ResultReg = '0;
        OutBReg = '0;
        WrRegReg = '0;
        MEMReg = '0;
        WBReg = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;

        // reset state
        @(posedge clk); #1;
        chk("rst_wb", 32'(WBOut), 0);
        chk("rst_rd", ReadDataOut, 0);
        chk("rst_res", ResultOut, 0);
        chk("rst_wr", 32'(WrRegOut), 0);
        chk("rst_err", 32'(mem_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU bundle, stray ack must be ignored
        @(negedge clk);
        WBReg = 2'b10; ResultReg = 32'h1234; WrRegReg = 5'd5;
        mem_ack = 1'b1;
        #1;
        chk("alu_stall", 32'(stall), 0);
        chk("alu_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        chk("alu_wb", 32'(WBOut), 2);
        chk("alu_res", ResultOut, 32'h1234);
        chk("alu_wr", 32'(WrRegOut), 5);

        // load, ack in third cycle
        @(negedge clk);
        MEMReg = 4'b0100; WBReg = 2'b11; ResultReg = 32'h100;
        WrRegReg = 5'd7; mem_ack = 1'b0;
        #1;
        chk("ld_stall1", 32'(stall), 1);
        chk("ld_req", 32'(mem_req), 1);
        chk("ld_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        chk("ld_bub1", 32'(WBOut), 0);
        @(negedge clk); #1;
        chk("ld_stall2", 32'(stall), 1);
        @(posedge clk); #1;
        chk("ld_bub2", 32'(WBOut), 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall3", 32'(stall), 0);
        @(posedge clk); #1;
        chk("ld_data", ReadDataOut, 32'hDEADBEEF);
        chk("ld_wb", 32'(WBOut), 3);
        chk("ld_wr", 32'(WrRegOut), 7);

        // zero-wait store back-to-back
        @(negedge clk);
        MEMReg = 4'b0010; WBReg = 2'b00; ResultReg = 32'h200;
        OutBReg = 32'hCAFE; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        #1;
        chk("st_we", 32'(mem_we), 1);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_wdata", mem_wdata, 32'hCAFE);
        chk("st_stall", 32'(stall), 0);
        @(posedge clk); #1;
        chk("st_wb", 32'(WBOut), 0);
        chk("st_rdhold", ReadDataOut, 32'hDEADBEEF);
        chk("st_res", ResultOut, 32'h200);

        // load that never acks
        @(negedge clk);
        MEMReg = 4'b0100; WBReg = 2'b11; ResultReg = 32'h300;
        WrRegReg = 5'd9; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_stall%0d", i), 32'(stall), 1);
            chk($sformatf("to_err%0d", i), 32'(mem_err), 0);
            @(negedge clk);
        end
        #1;
        chk("to_stall_end", 32'(stall), 0);
        @(posedge clk); #1;
        chk("to_err", 32'(mem_err), 1);
        chk("to_wb", 32'(WBOut), 0);
        chk("to_wr", 32'(WrRegOut), 0);
        chk("to_res", ResultOut, 32'h200);
        @(negedge clk);
        MEMReg = 4'b0000; WBReg = 2'b00;
        @(posedge clk); #1;
        chk("to_err_drop", 32'(mem_err), 0);

        // branches
        @(negedge clk);
        MEMReg = 4'b1000; PCPlus4PlusOffReg = 32'h400; EqualReg = 1'b1;
        #1;
        chk("beq_t", 32'(pc_src), 1);
        chk("beq_tgt", branch_target, 32'h400);
        chk("beq_stall", 32'(stall), 0);
        EqualReg = 1'b0; #1;
        chk("beq_nt", 32'(pc_src), 0);
        MEMReg = 4'b0001; #1;
        chk("bne_t", 32'(pc_src), 1);
        EqualReg = 1'b1; #1;
        chk("bne_nt", 32'(pc_src), 0);

        // reset during the second WAIT cycle
        @(negedge clk);
        MEMReg = 4'b0100; WBReg = 2'b11; ResultReg = 32'h500;
        WrRegReg = 5'd3; mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr_wb", 32'(WBOut), 0);
        chk("mr_rd", ReadDataOut, 0);
        chk("mr_res", ResultOut, 0);
        chk("mr_wr", 32'(WrRegOut), 0);
        chk("mr_req", 32'(mem_req), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_restart", 32'(stall), 1);
        @(posedge clk); #1;
        chk("mr_bub", 32'(WBOut), 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h55AA;
        @(posedge clk); #1;
        chk("mr_data", ReadDataOut, 32'h55AA);
        chk("mr_wb2", 32'(WBOut), 3);
        chk("mr_wr2", 32'(WrRegOut), 3);
        chk("mr_res2", ResultOut, 32'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the registered EX/MEM bundle (branch target, Equal flag, ALU result, store data, destination register, MEM/WB control).
- Resolves the branch, runs the data-memory access over a req/ack handshake with variable latency, and produces the registered MEM/WB bundle.
- While an access is outstanding it asserts stall, which tells upstream stages (including EX/MEM) to hold; a watchdog aborts hung accesses.

Parameters:
- DATA_W, 32, data/result width
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (≥1)
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- PCPlus4PlusOffReg  input  32  branch target from EX/MEM
- EqualReg  input  1  ALU zero/equal flag
- ResultReg  input  DATA_W  ALU result / memory address
- OutBReg  input  DATA_W  store data
- WrRegReg  input  5  destination register
- MEMReg  input  4  [3]=Branch [2]=MemRead [1]=MemWrite [0]=BranchNE
- WBReg  input  2  [1]=RegWrite [0]=MemtoReg
- mem_req  output  1  memory request
- mem_we  output  1  1=write, 0=read
- mem_addr  output  32  byte address (=ResultReg)
- mem_wdata  output  DATA_W  =OutBReg
- mem_rdata  input  DATA_W  read data, valid in mem_ack cycle
- mem_ack  input  1  access complete
- stall  output  1  hold upstream stages
- pc_src  output  1  take branch
- branch_target  output  32  =PCPlus4PlusOffReg
- mem_err  output  1  one-cycle pulse on watchdog abort
- WBOut  output  2  MEM/WB control
- ReadDataOut  output  DATA_W  registered load data
- ResultOut  output  DATA_W  registered ALU result
- WrRegOut  output  5  registered destination

Behaviour:
- Reset (async): state=IDLE, counter=0, WBOut=0, ReadDataOut=0, ResultOut=0, WrRegOut=0, mem_err=0. Combinational outputs follow their equations once inputs settle.
- mem_op = MEMReg[2] | MEMReg[1]. If both bits are set, treat the access as a write.
- pc_src = (MEMReg[3] & EqualReg) | (MEMReg[0] & ~EqualReg).
  - Combinational; never depends on state.
  - Branch bundles carry no memory op and never stall.
- FSM states: IDLE, WAIT.
- mem_req = mem_op in both states. mem_we = MEMReg[1]. mem_addr and mem_wdata track the inputs, which stay stable because upstream holds during stall.
- IDLE:
  - mem_op & mem_ack: zero-wait completion, stay IDLE.
  - mem_op & ~mem_ack: go to WAIT, counter=1.
- WAIT:
  - mem_ack: complete, go to IDLE, counter=0.
  - ~mem_ack & counter==TIMEOUT: abort, pulse mem_err, go to IDLE, counter=0.
  - Otherwise: counter+1.
- stall = mem_op & ~mem_ack & ~abort, where abort = (state==WAIT & counter==TIMEOUT & ~mem_ack).
- Completion cycle: stall=0. Upstream advances on the same edge that captures the MEM/WB bundle.
- MEM/WB capture on each rising edge:
  - If stall: WBOut=0 (bubble inserted), other MEM/WB regs unchanged.
  - Else if abort: WBOut=0, WrRegOut=0; mem_err=1 for this cycle only.
  - Else: WBOut=WBReg, ResultOut=ResultReg, WrRegOut=WrRegReg, ReadDataOut = mem_rdata if MemRead else holds previous value.
- Non-memory bundles pass through in 1 cycle. Memory bundles take 1+N cycles, N = ack wait cycles.
- Back-to-back memory ops: after completion the next op is presented the next cycle and starts in IDLE with no dead cycle.
- mem_ack with mem_req=0 is ignored.
- Reset mid-access: FSM returns to IDLE immediately and mem_req follows the inputs. The memory is required to drop any pending transaction on rst.

Decomposition:
- Shared pipeline package holds:
  - MEM bit indices MEM_BRANCH=3, MEM_READ=2, MEM_WRITE=1, MEM_BNE=0
  - WB bit indices WB_REGWRITE=1, WB_MEMTOREG=0
  - State encodings ST_IDLE, ST_WAIT
- One natural sub-module: mem_watchdog (counter + TIMEOUT compare, outputs abort). Everything else stays in mem_wb_stage.

Test Plan:
- ALU bundle (MEMReg=0, WBReg=2'b10, ResultReg=0x1234, WrRegReg=5) -> stall=0; next edge WBOut=2'b10, ResultOut=0x1234, WrRegOut=5.
- Load with mem_ack at the 3rd cycle, mem_rdata=0xDEADBEEF -> stall high 2 cycles with WBOut=0 bubbles; then ReadDataOut=0xDEADBEEF, WBOut=2'b11.
- Store with zero-wait ack (mem_ack same cycle as req) -> mem_we=1, mem_addr=ResultReg, stall never asserts, WBOut=0.
- Load with no ack, TIMEOUT=4 -> stall high 4 cycles, then mem_err pulses exactly 1 cycle, WBOut=0, FSM back to IDLE.
- Branch with MEMReg=4'b1000: EqualReg=1 gives pc_src=1 and branch_target=0x400; EqualReg=0 gives pc_src=0. BNE with MEMReg=4'b0001 gives the inverse.
- rst asserted in the 2nd WAIT cycle of a load -> all registered outputs 0 asynchronously; after release the load restarts and completes normally.
